write_back_register_file: RTL

- Write-back stage and architectural register file of the five-stage MIPS pipeline, merged into one block.
- Consumes the MEM/WB pipeline register outputs and selects the write-back value with MemToReg.
- Commits that value to a 32 x 32-bit register file.
- Serves the two combinational read ports used by the decode stage.
- Keeps a retired-write counter for debug.

---
 rtl/write_back_register_file.sv | 101 ++++++++++
 1 files changed

// File: rtl/write_back_register_file.sv
// ---------------------------------------------------------------------------
// write_back_register_file
//   Write-back stage merged with the architectural register file of a
//   five-stage MIPS pipeline. Selects the write-back value from the MEM/WB
//   register outputs, commits it to a 2^ADDR_WIDTH x DATA_WIDTH register
//   array, serves two combinational decode read ports and counts retired
//   (non-zero-register) writes for debug.
//
//   Optional feature macro: WB_REGFILE_BYPASS_EN
//     defined   -> a read of the register being written this cycle returns
//                  WriteBackData (write-before-read forwarding), except
//                  while Reset is high.
//     undefined -> reads always return the array contents.
//
// Ports
//   Clock          in   clock, all state updates on posedge
//   Reset          in   synchronous active-high reset
//   RegWriteIn     in   write enable from MEM/WB
//   MemToRegIn     in   1 = load data, 0 = ALU result
//   MemReadDataIn  in   load data from MEM/WB
//   ALUResultIn    in   ALU result from MEM/WB
//   WriteRegIn     in   destination register index
//   ReadReg1/2     in   decode read indices
//   ReadData1/2    out  register contents at ReadReg1/2 (combinational)
//   WriteBackData  out  selected write-back value (combinational)
//   WriteCount     out  committed non-zero-register writes since reset
// ---------------------------------------------------------------------------
module write_back_register_file #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  RegWriteIn,
    input  logic                  MemToRegIn,
    input  logic [DATA_WIDTH-1:0] MemReadDataIn,
    input  logic [DATA_WIDTH-1:0] ALUResultIn,
    input  logic [ADDR_WIDTH-1:0] WriteRegIn,
    input  logic [ADDR_WIDTH-1:0] ReadReg1,
    input  logic [ADDR_WIDTH-1:0] ReadReg2,
    output logic [DATA_WIDTH-1:0] ReadData1,
    output logic [DATA_WIDTH-1:0] ReadData2,
    output logic [DATA_WIDTH-1:0] WriteBackData,
    output logic [31:0]           WriteCount
);

    localparam int unsigned NUM_REGS  = 1 << ADDR_WIDTH;
    localparam int unsigned CNT_WIDTH = 32;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic [CNT_WIDTH-1:0]  wcount_q;
    logic [CNT_WIDTH-1:0]  wcount_d;

    logic                  commit_c;
    logic [DATA_WIDTH-1:0] rd1_arr_c;
    logic [DATA_WIDTH-1:0] rd2_arr_c;

    // Write-back mux, evaluated every cycle independent of RegWriteIn.
    assign WriteBackData = MemToRegIn ? MemReadDataIn : ALUResultIn;

    // Writes to register 0 are discarded; reset gating lives in the flops.
    assign commit_c = RegWriteIn && (WriteRegIn != '0);

    // Next-state: update one array entry and bump the retire counter.
    always_comb begin
        regs_d   = regs_q;
        wcount_d = wcount_q;
        if (commit_c) begin
            regs_d[WriteRegIn] = WriteBackData;
            wcount_d           = wcount_q + CNT_WIDTH'(1);
        end
    end

    // State registers; reset wins over any write presented in the same cycle.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            regs_q   <= '{default: '0};
            wcount_q <= '0;
        end else begin
            regs_q   <= regs_d;
            wcount_q <= wcount_d;
        end
    end

    // Array reads; index 0 is forced to zero regardless of storage.
    assign rd1_arr_c = (ReadReg1 == '0) ? '0 : regs_q[ReadReg1];
    assign rd2_arr_c = (ReadReg2 == '0) ? '0 : regs_q[ReadReg2];

`ifdef WB_REGFILE_BYPASS_EN
    // Forward the in-flight write so decode sees it in the same cycle.
    assign ReadData1 = (!Reset && commit_c && (ReadReg1 == WriteRegIn)) ? WriteBackData : rd1_arr_c;
    assign ReadData2 = (!Reset && commit_c && (ReadReg2 == WriteRegIn)) ? WriteBackData : rd2_arr_c;
`else
    assign ReadData1 = rd1_arr_c;
    assign ReadData2 = rd2_arr_c;
`endif

    assign WriteCount = wcount_q;

endmodule
